// File: rtl/dcache_victim_reader_if.sv
// Purpose : bundles the request, bank-read, memory write (AW/W/B) and completion
//           signals of the D-cache victim reader.
// Ports   : master = the reader's own view (takes requests, drives bank_r_set,
//           masters the memory write channel, reports done); slave = its environment.
interface dcache_victim_reader_if #(
  parameter int NBANK  = 4,
  parameter int NWAY   = 4,
  parameter int SET_W  = 6,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int OFF_W = $clog2(NBANK * DATA_W / 8);
  localparam int TAG_W = ADDR_W - SET_W - OFF_W;

  logic                          req_valid;
  logic                          req_ready;
  logic [SET_W-1:0]              req_set;
  logic [NWAY-1:0]               req_way;
  logic [TAG_W-1:0]              req_tag;
  logic [SET_W-1:0]              bank_r_set;
  logic [NBANK*NWAY*DATA_W-1:0]  bank_r_data;
  logic                          mem_aw_valid;
  logic                          mem_aw_ready;
  logic [ADDR_W-1:0]             mem_aw_addr;
  logic                          mem_w_valid;
  logic                          mem_w_ready;
  logic [DATA_W-1:0]             mem_w_data;
  logic                          mem_w_last;
  logic                          mem_b_valid;
  logic                          mem_b_ready;
  logic [1:0]                    mem_b_resp;
  logic                          done;
  logic                          done_err;

  modport master (
    input  req_valid, req_set, req_way, req_tag,
    output req_ready,
    output bank_r_set,
    input  bank_r_data,
    output mem_aw_valid, mem_aw_addr,
    input  mem_aw_ready,
    output mem_w_valid, mem_w_data, mem_w_last,
    input  mem_w_ready,
    input  mem_b_valid, mem_b_resp,
    output mem_b_ready,
    output done, done_err
  );

  modport slave (
    output req_valid, req_set, req_way, req_tag,
    input  req_ready,
    input  bank_r_set,
    output bank_r_data,
    input  mem_aw_valid, mem_aw_addr,
    output mem_aw_ready,
    input  mem_w_valid, mem_w_data, mem_w_last,
    output mem_w_ready,
    output mem_b_valid, mem_b_resp,
    input  mem_b_ready,
    input  done, done_err
  );
endinterface

// File: rtl/dcache_victim_reader.sv
// Purpose : reads one dirty victim line from the D-cache data banks into a local
//           line buffer and writes it back to memory as one AW, NBANK W beats, one B.
// Ports   : clk/rst (async, active-high) plus bus (dcache_victim_reader_if.master).
//           Optional macro VICTIM_READER_PERF_EN adds perf_wb_cnt / perf_stall_cnt.
// Latency : 5 + NBANK cycles accept->done with all readies high; all outputs registered.
module dcache_victim_reader #(
  parameter int NBANK  = 4,
  parameter int NWAY   = 4,
  parameter int SET_W  = 6,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  dcache_victim_reader_if.master bus
`ifdef VICTIM_READER_PERF_EN
  ,
  output logic [31:0] perf_wb_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int OFF_W = $clog2(NBANK * DATA_W / 8);
  localparam int TAG_W = ADDR_W - SET_W - OFF_W;
  localparam int WAY_W = (NWAY > 1) ? $clog2(NWAY) : 1;
  localparam int CNT_W = (NBANK > 1) ? $clog2(NBANK) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_AW, S_W, S_B, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic               aw_valid_q, aw_valid_d;
  logic [ADDR_W-1:0]  aw_addr_q, aw_addr_d;
  logic               w_valid_q, w_valid_d;
  logic [DATA_W-1:0]  w_data_q, w_data_d;
  logic               w_last_q, w_last_d;
  logic               b_ready_q, b_ready_d;
  logic               done_q, done_d;
  logic               done_err_q, done_err_d;
  logic [DATA_W-1:0]  line_q [NBANK];
  logic [DATA_W-1:0]  line_d [NBANK];
  logic [WAY_W-1:0]   req_way_idx;
  logic               req_way_any;

  // Lowest set bit wins when the one-hot way is malformed.
  always_comb begin
    req_way_idx = '0;
    for (int i = NWAY - 1; i >= 0; i--) begin
      if (bus.req_way[i]) req_way_idx = WAY_W'(i);
    end
    req_way_any = |bus.req_way;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    set_d       = set_q;
    tag_d       = tag_q;
    way_d       = way_q;
    cnt_d       = cnt_q;
    cnt_nxt     = cnt_q + 1'b1;
    aw_valid_d  = aw_valid_q;
    aw_addr_d   = aw_addr_q;
    w_valid_d   = w_valid_q;
    w_data_d    = w_data_q;
    w_last_d    = w_last_q;
    b_ready_d   = b_ready_q;
    done_d      = 1'b0;
    done_err_d  = 1'b0;
    line_d      = line_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          set_d       = bus.req_set;
          tag_d       = bus.req_tag;
          way_d       = req_way_idx;
          req_ready_d = 1'b0;
          if (req_way_any) begin
            state_d = S_RD;
          end else begin
            // No way to evict: report an error without touching memory.
            state_d    = S_DONE;
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        // Bank data for set_q is valid this cycle; snapshot the victim way so
        // later bank writes cannot leak into the writeback.
        for (int b = 0; b < NBANK; b++) begin
          line_d[b] = bus.bank_r_data[(b * NWAY + int'(way_q)) * DATA_W +: DATA_W];
        end
        aw_valid_d = 1'b1;
        aw_addr_d  = {tag_q, set_q, {OFF_W{1'b0}}};
        state_d    = S_AW;
      end
      S_AW: begin
        if (bus.mem_aw_ready) begin
          aw_valid_d = 1'b0;
          w_valid_d  = 1'b1;
          w_data_d   = line_q[0];
          w_last_d   = (NBANK == 1);
          cnt_d      = '0;
          state_d    = S_W;
        end
      end
      S_W: begin
        if (bus.mem_w_ready) begin
          if (cnt_q == CNT_W'(NBANK - 1)) begin
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
            b_ready_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_B;
          end else begin
            cnt_d    = cnt_nxt;
            w_data_d = line_q[cnt_nxt];
            w_last_d = (cnt_nxt == CNT_W'(NBANK - 1));
          end
        end
      end
      S_B: begin
        if (bus.mem_b_valid) begin
          b_ready_d  = 1'b0;
          done_d     = 1'b1;
          done_err_d = (bus.mem_b_resp != 2'b00);
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      set_q       <= '0;
      tag_q       <= '0;
      way_q       <= '0;
      cnt_q       <= '0;
      aw_valid_q  <= 1'b0;
      aw_addr_q   <= '0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      w_last_q    <= 1'b0;
      b_ready_q   <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      set_q       <= set_d;
      tag_q       <= tag_d;
      way_q       <= way_d;
      cnt_q       <= cnt_d;
      aw_valid_q  <= aw_valid_d;
      aw_addr_q   <= aw_addr_d;
      w_valid_q   <= w_valid_d;
      w_data_q    <= w_data_d;
      w_last_q    <= w_last_d;
      b_ready_q   <= b_ready_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
    end
  end

  // Line buffer contents are meaningless until CAP, so it needs no reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  // The latched set keeps the bank read address stable for the whole operation.
  assign bus.req_ready    = req_ready_q;
  assign bus.bank_r_set   = set_q;
  assign bus.mem_aw_valid = aw_valid_q;
  assign bus.mem_aw_addr  = aw_addr_q;
  assign bus.mem_w_valid  = w_valid_q;
  assign bus.mem_w_data   = w_data_q;
  assign bus.mem_w_last   = w_last_q;
  assign bus.mem_b_ready  = b_ready_q;
  assign bus.done         = done_q;
  assign bus.done_err     = done_err_q;

`ifdef VICTIM_READER_PERF_EN
  logic [31:0] perf_wb_q, perf_wb_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall_now;

  always_comb begin
    stall_now    = ((state_q == S_AW) && aw_valid_q && !bus.mem_aw_ready) ||
                   ((state_q == S_W)  && w_valid_q  && !bus.mem_w_ready);
    perf_wb_d    = perf_wb_q + {31'd0, done_q};
    perf_stall_d = perf_stall_q + {31'd0, stall_now};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_wb_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_wb_q    <= perf_wb_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_wb_cnt    = perf_wb_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_dcache_victim_reader.sv
// Bench for dcache_victim_reader: directed and randomized writebacks checked
// against a line-level reference (lowest-bit way pick, {tag,set,0} address,
// 5+NBANK+stall latency, error = bad way or nonzero response).
module tb_dcache_victim_reader;
  localparam int NBANK  = 4;
  localparam int NWAY   = 4;
  localparam int SET_W  = 6;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int OFF_W  = $clog2(NBANK * DATA_W / 8);
  localparam int TAG_W  = ADDR_W - SET_W - OFF_W;
  localparam int NSET   = 1 << SET_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  logic [DATA_W-1:0] mem_arr [NBANK][NWAY][NSET];

  dcache_victim_reader_if #(.NBANK(NBANK), .NWAY(NWAY), .SET_W(SET_W),
                            .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef VICTIM_READER_PERF_EN
  logic [31:0] perf_wb_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  dcache_victim_reader #(.NBANK(NBANK), .NWAY(NWAY), .SET_W(SET_W),
                         .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef VICTIM_READER_PERF_EN
    ,
    .perf_wb_cnt    (perf_wb_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read data banks: one cycle from bank_r_set to bank_r_data.
  always @(posedge clk) begin
    for (int b = 0; b < NBANK; b++)
      for (int w = 0; w < NWAY; w++)
        bus.bank_r_data[(b * NWAY + w) * DATA_W +: DATA_W] <= mem_arr[b][w][bus.bank_r_set];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vecs++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int low_way(input logic [NWAY-1:0] w);
    for (int i = 0; i < NWAY; i++) if (w[i]) return i;
    return -1;
  endfunction

  // One writeback: present the request, play the memory side with the given
  // delays, check every beat/address against the model, then the summary.
  task automatic run_wb(input string nm, input logic [SET_W-1:0] set,
                        input logic [NWAY-1:0] way, input logic [TAG_W-1:0] tag,
                        input int aw_delay, input int ws_beat, input int ws_len,
                        input int b_delay, input logic [1:0] resp,
                        input bit hold_req, input bit overwrite, input int abort_beats);
    logic [DATA_W-1:0] exp_line [NBANK];
    logic [ADDR_W-1:0] exp_addr, prev_addr;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last, err_seen;
    int  wi, cyc, beats, aw_hs, aw_wait, ws_cnt, b_wait, exp_lat, lat;
    int  overlap, unstable, busy_rdy;
    bit  done_seen, ow_done, prev_aw_stall, prev_w_stall;
    wi = low_way(way);
    for (int b = 0; b < NBANK; b++) exp_line[b] = (wi >= 0) ? mem_arr[b][wi][set] : '0;
    exp_addr = ADDR_W'((longint'(tag) << (SET_W + OFF_W)) + (longint'(set) << OFF_W));
    // Bad way goes straight to the one-cycle DONE state; otherwise the
    // fixed pipeline plus every stall cycle injected on AW, W and B.
    exp_lat  = (wi < 0) ? 1 : 5 + NBANK + aw_delay + ws_len + b_delay;
    cyc = 0; beats = 0; aw_hs = 0; aw_wait = 0; ws_cnt = 0; b_wait = 0; lat = -1;
    overlap = 0; unstable = 0; busy_rdy = 0;
    done_seen = 0; ow_done = 0; prev_aw_stall = 0; prev_w_stall = 0; err_seen = 1'b0;
    prev_addr = '0; prev_data = '0; prev_last = 1'b0;

    @(negedge clk);
    chk({nm, ".req_ready_idle"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_set   = set;
    bus.req_way   = way;
    bus.req_tag   = tag;
    while (!done_seen && cyc < 100 && !(abort_beats > 0 && beats >= abort_beats)) begin
      @(negedge clk);
      cyc++;
      if (!hold_req) bus.req_valid = 1'b0;
      else if (bus.req_ready) busy_rdy++;
      if (bus.done) begin
        done_seen = 1;
        lat       = cyc;
        err_seen  = bus.done_err;
      end
      if (bus.mem_aw_valid && bus.mem_w_valid) overlap++;
      if (prev_aw_stall && (!bus.mem_aw_valid || bus.mem_aw_addr !== prev_addr)) unstable++;
      if (prev_w_stall && (!bus.mem_w_valid || bus.mem_w_data !== prev_data ||
                           bus.mem_w_last !== prev_last)) unstable++;
      if (overwrite && bus.mem_aw_valid && !ow_done) begin
        for (int b = 0; b < NBANK; b++) mem_arr[b][wi][set] = ~exp_line[b];
        ow_done = 1;
      end
      bus.mem_aw_ready = (aw_wait >= aw_delay);
      if (bus.mem_aw_valid) aw_wait++;
      bus.mem_w_ready = !(beats == ws_beat && ws_cnt < ws_len);
      if (bus.mem_w_valid && !bus.mem_w_ready) ws_cnt++;
      if (bus.mem_b_ready) begin
        bus.mem_b_valid = (b_wait >= b_delay);
        bus.mem_b_resp  = resp;
        b_wait++;
      end else begin
        // Stray responses outside the B phase must be ignored.
        bus.mem_b_valid = 1'($urandom_range(0, 1));
        bus.mem_b_resp  = 2'b11;
      end
      if (bus.mem_aw_valid && bus.mem_aw_ready) begin
        aw_hs++;
        chk({nm, ".aw_addr"}, bus.mem_aw_addr, exp_addr);
      end
      if (bus.mem_w_valid && bus.mem_w_ready) begin
        if (beats < NBANK) begin
          chk({nm, ".w_data"}, bus.mem_w_data, exp_line[beats]);
          chk({nm, ".w_last"}, bus.mem_w_last, (beats == NBANK - 1));
        end
        beats++;
      end
      prev_aw_stall = bus.mem_aw_valid && !bus.mem_aw_ready;
      prev_w_stall  = bus.mem_w_valid && !bus.mem_w_ready;
      prev_addr     = bus.mem_aw_addr;
      prev_data     = bus.mem_w_data;
      prev_last     = bus.mem_w_last;
    end
    bus.req_valid    = 1'b0;
    bus.mem_b_valid  = 1'b0;
    bus.mem_aw_ready = 1'b1;
    bus.mem_w_ready  = 1'b1;
    chk({nm, ".overlap"}, overlap, 0);
    chk({nm, ".unstable"}, unstable, 0);
    if (abort_beats == 0) begin
      chk({nm, ".done_seen"}, done_seen, 1);
      chk({nm, ".latency"}, lat, exp_lat);
      chk({nm, ".done_err"}, err_seen, (wi < 0 || resp != 2'b00));
      chk({nm, ".beats"}, beats, (wi < 0) ? 0 : NBANK);
      chk({nm, ".aw_count"}, aw_hs, (wi < 0) ? 0 : 1);
      if (hold_req) chk({nm, ".busy_ready"}, busy_rdy, 0);
      @(negedge clk);
      chk({nm, ".done_pulse"}, bus.done, 0);
      chk({nm, ".ready_after"}, bus.req_ready, 1);
    end
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_set      = '0;
    bus.req_way      = '0;
    bus.req_tag      = '0;
    bus.mem_aw_ready = 1'b1;
    bus.mem_w_ready  = 1'b1;
    bus.mem_b_valid  = 1'b0;
    bus.mem_b_resp   = 2'b00;
    for (int b = 0; b < NBANK; b++)
      for (int w = 0; w < NWAY; w++)
        for (int s = 0; s < NSET; s++) mem_arr[b][w][s] = $urandom;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.req_ready", bus.req_ready, 1);
    chk("rst.aw_valid", bus.mem_aw_valid, 0);
    chk("rst.w_valid", bus.mem_w_valid, 0);
    chk("rst.w_last", bus.mem_w_last, 0);
    chk("rst.b_ready", bus.mem_b_ready, 0);
    chk("rst.done", {bus.done, bus.done_err}, 0);
    chk("rst.bank_r_set", bus.bank_r_set, 0);
    rst = 1'b0;

    // T1 basic
    for (int b = 0; b < NBANK; b++) mem_arr[b][2][6'h15] = 32'hB0B0_0000 + 32'(b);
    run_wb("t1", 6'h15, 4'b0100, 22'h2A5A5, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    // T2 backpressure: AW delayed 2, beat 1 stalled 3
    run_wb("t2", 6'h15, 4'b0100, 22'h2A5A5, 2, 1, 3, 0, 2'b00, 0, 0, 0);
    // T3 error response and bad way
    run_wb("t3a", 6'h07, 4'b0001, 22'h1234, 0, 0, 0, 1, 2'b10, 0, 0, 0);
    run_wb("t3b", 6'h08, 4'b0000, 22'h3FFFFF, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    // T4 isolation with request held high while busy
    run_wb("t4", 6'h2C, 4'b0100, 22'h0ABCD, 2, 2, 1, 0, 2'b00, 1, 1, 0);
    // Malformed way: lowest set bit (way 1) is evicted
    run_wb("mway", 6'h3F, 4'b1010, 22'h155555, 0, 3, 2, 0, 2'b00, 0, 0, 0);
    // Randomized writebacks
    for (int i = 0; i < 8; i++) begin
      run_wb("rnd", SET_W'($urandom), NWAY'($urandom_range(0, 15)), TAG_W'($urandom),
             $urandom_range(0, 3), $urandom_range(0, NBANK - 1), $urandom_range(0, 3),
             $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             0, 0, 0);
    end

    // T5 reset after beat 1
    run_wb("t5", 6'h11, 4'b1000, 22'h2F0F0, 0, 0, 0, 0, 2'b00, 0, 0, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5.aw_valid", bus.mem_aw_valid, 0);
    chk("t5.w_valid", bus.mem_w_valid, 0);
    chk("t5.b_ready", bus.mem_b_ready, 0);
    chk("t5.req_ready", bus.req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5.no_done", bus.done, 0);
    end

    // Next requests complete normally; T6 stalls: 1+1 then 0+2
    run_wb("t6a", 6'h11, 4'b1000, 22'h2F0F0, 1, 0, 1, 0, 2'b00, 0, 0, 0);
    run_wb("t6b", 6'h05, 4'b0010, 22'h00777, 0, 3, 2, 1, 2'b00, 0, 0, 0);
`ifdef VICTIM_READER_PERF_EN
    chk("t6.perf_wb", perf_wb_cnt, 2);
    chk("t6.perf_stall", perf_stall_cnt, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
